// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, state
// codes, mux/ALU encodings and the bundled control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Codes 12-15 are unused; the FSM recovers from them to FETCH.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } stateT;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memToReg;
        logic       regWrite;
        logic       regDst;
        logic       aluSrcA;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic [1:0] aluSrcB;
        logic       instrDone;
        logic       illegalOp;
    } ctrlT;

    localparam ctrlT CTRL_IDLE = '0;

    function automatic logic isSupported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

    function automatic logic isMemOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Per-state datapath control decode. Purely combinational: every output is a
// function of the current state, the opcode and mem_ready only.
module mc_ctrl_decode
    import mips_pkg::*;
(
    input  stateT      state,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output ctrlT       ctrl
);

    // Decode the control word; anything not set for a state stays low.
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.iOrD     = 1'b0;
                ctrl.aluSrcA  = 1'b0;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOp    = ALUOP_ADD;
                ctrl.pcSource = PCSRC_ALU;
                // IR and PC only latch once the instruction word is valid.
                ctrl.irWrite  = memReady;
                ctrl.pcWrite  = memReady;
            end
            DECODE: begin
                ctrl.aluSrcA   = 1'b0;
                ctrl.aluSrcB   = SRCB_IMMSH;
                ctrl.aluOp     = ALUOP_ADD;
                ctrl.illegalOp = ~isSupported(opcode);
            end
            MEMADR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iOrD    = 1'b1;
            end
            MEMWB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.memToReg  = 1'b1;
                ctrl.regDst    = 1'b0;
                ctrl.instrDone = 1'b1;
            end
            MEMWR: begin
                ctrl.memWrite  = 1'b1;
                ctrl.iOrD      = 1'b1;
                // A store retires in the cycle the memory accepts it.
                ctrl.instrDone = memReady;
            end
            EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_REG;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            RWB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.regDst    = 1'b1;
                ctrl.memToReg  = 1'b0;
                ctrl.instrDone = 1'b1;
            end
            BRANCH: begin
                // The zero flag gates PCWriteCond in the datapath, not here.
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluSrcB     = SRCB_REG;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
                ctrl.instrDone   = 1'b1;
            end
            JUMP: begin
                ctrl.pcWrite   = 1'b1;
                ctrl.pcSource  = PCSRC_JUMP;
                ctrl.instrDone = 1'b1;
            end
            ADDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            ADDIWB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.regDst    = 1'b0;
                ctrl.memToReg  = 1'b0;
                ctrl.instrDone = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, next-state logic and the
// per-state control decode. Outputs are forced low while rst is high.
//
//   state  | meaning
//   -------+---------------------------------------------
//   FETCH  | read instruction, PC+4; waits for mem_ready
//   DECODE | branch target calc, dispatch on opcode
//   MEMADR | lw/sw effective address
//   MEMRD  | load data read; waits for mem_ready
//   MEMWB  | load writeback (retire)
//   MEMWR  | store write; waits for mem_ready (retire)
//   EXEC   | R-type ALU operation
//   RWB    | R-type writeback (retire)
//   BRANCH | beq compare, conditional PC write (retire)
//   JUMP   | jump PC write (retire)
//   ADDIEX | addi ALU operation
//   ADDIWB | addi writeback (retire)
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    stateT stateQ;
    stateT stateD;
    ctrlT  ctrlDec;
    ctrlT  ctrlOut;

    // The branch decision is made in the datapath; zero never reaches the
    // controller's outputs.
    logic  unusedZero;
    assign unusedZero = zero;

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= FETCH;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state selection.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            FETCH: begin
                if (mem_ready) begin
                    stateD = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: stateD = MEMADR;
                    OP_RTYPE:     stateD = EXEC;
                    OP_BEQ:       stateD = BRANCH;
                    OP_J:         stateD = JUMP;
                    OP_ADDI:      stateD = ADDIEX;
                    default:      stateD = FETCH;
                endcase
            end
            MEMADR: begin
                // The IR is stable here; a non-memory opcode can only appear if
                // the IR was disturbed, so drop the instruction.
                if (!isMemOp(opcode)) begin
                    stateD = FETCH;
                end else if (opcode == OP_LW) begin
                    stateD = MEMRD;
                end else begin
                    stateD = MEMWR;
                end
            end
            MEMRD: begin
                if (mem_ready) begin
                    stateD = MEMWB;
                end
            end
            MEMWB:   stateD = FETCH;
            MEMWR: begin
                if (mem_ready) begin
                    stateD = FETCH;
                end
            end
            EXEC:    stateD = RWB;
            RWB:     stateD = FETCH;
            BRANCH:  stateD = FETCH;
            JUMP:    stateD = FETCH;
            ADDIEX:  stateD = ADDIWB;
            ADDIWB:  stateD = FETCH;
            default: stateD = FETCH;
        endcase
    end

    mc_ctrl_decode uDecode (
        .state    (stateQ),
        .opcode   (opcode),
        .memReady (mem_ready),
        .ctrl     (ctrlDec)
    );

    // Reset masks the decode asynchronously so no strobe leaks while rst is high.
    assign ctrlOut = rst ? CTRL_IDLE : ctrlDec;

    assign PCWrite     = ctrlOut.pcWrite;
    assign PCWriteCond = ctrlOut.pcWriteCond;
    assign IorD        = ctrlOut.iOrD;
    assign MemRead     = ctrlOut.memRead;
    assign MemWrite    = ctrlOut.memWrite;
    assign IRWrite     = ctrlOut.irWrite;
    assign MemtoReg    = ctrlOut.memToReg;
    assign RegWrite    = ctrlOut.regWrite;
    assign RegDst      = ctrlOut.regDst;
    assign ALUSrcA     = ctrlOut.aluSrcA;
    assign ALUOp       = ctrlOut.aluOp;
    assign PCSource    = ctrlOut.pcSource;
    assign ALUSrcB     = ctrlOut.aluSrcB;
    assign instr_done  = ctrlOut.instrDone;
    assign illegal_op  = ctrlOut.illegalOp;
    assign state       = stateQ;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port opcode, input, 6: instruction[31:26] taken from the instruction register.
REQ-004 SHALL have port zero, input, 1: ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1: memory completes the current access this cycle.
REQ-006 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, each output, 1: standard multicycle MIPS datapath controls.
REQ-007 SHALL have ports ALUOp, PCSource and ALUSrcB, each output, 2: ALU op class, PC mux select and ALU B mux select.
REQ-008 SHALL have port instr_done, output, 1: one-cycle pulse in the final cycle of each instruction.
REQ-009 SHALL have port illegal_op, output, 1: one-cycle pulse in DECODE on an unsupported opcode.
REQ-010 SHALL have port state, output, 4: current state code, for debug.

Function
REQ-011 SHALL support these opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-012 SHALL use state codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-013 SHALL, in FETCH, drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00; IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1, after which the next state is DECODE; otherwise stay in FETCH.
REQ-014 SHALL, in DECODE, drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00 (branch target), and branch by opcode: lw/sw->MEMADR, R-type->EXEC, beq->BRANCH, j->JUMP, addi->ADDIEX, any other->FETCH with illegal_op=1.
REQ-015 SHALL, in MEMADR, drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to MEMRD for lw or MEMWR for sw.
REQ-016 SHALL, in MEMRD, drive MemRead=1 and IorD=1; hold until mem_ready=1, then go to MEMWB.
REQ-017 SHALL, in MEMWB, drive RegWrite=1, MemtoReg=1, RegDst=0 and instr_done=1, then go to FETCH.
REQ-018 SHALL, in MEMWR, drive MemWrite=1 and IorD=1; hold until mem_ready=1, then go to FETCH with instr_done=1 in that cycle.
REQ-019 SHALL, in EXEC, drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10, then go to RWB.
REQ-020 SHALL, in RWB, drive RegWrite=1, RegDst=1, MemtoReg=0 and instr_done=1, then go to FETCH.
REQ-021 SHALL, in BRANCH, drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 and instr_done=1, then go to FETCH; the PC update is gated externally by zero.
REQ-022 SHALL, in JUMP, drive PCWrite=1, PCSource=10 and instr_done=1, then go to FETCH.
REQ-023 SHALL, in ADDIEX, drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00, then go to ADDIWB.
REQ-024 SHALL, in ADDIWB, drive RegWrite=1, RegDst=0, MemtoReg=0 and instr_done=1, then go to FETCH.
REQ-025 SHALL drive every output not listed for the current state to 0.
REQ-026 SHALL never assert MemRead and MemWrite in the same cycle.
REQ-027 SHALL decode each output only from state, opcode and mem_ready; zero SHALL NOT feed any output.
REQ-028 SHALL, for a state decoded as unused (codes 12-15), force all outputs to 0 and go to FETCH on the next edge.
REQ-029 SHALL give these latencies with mem_ready tied to 1: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.

Reset
REQ-030 SHALL, while rst=1, set state=FETCH immediately and force every output to 0, regardless of clk.
REQ-031 SHALL, after reset deassertion, spend the first clk cycle in FETCH with normal FETCH outputs.
REQ-032 SHALL, on reset during a pending memory access (MEMRD or MEMWR waiting), abandon the access with no RegWrite and no instr_done.

Structure
REQ-033 SHALL place opcode constants, the state enum/codes and the ALUOp encodings (00 add, 01 sub, 10 funct) in the shared package mips_pkg.
REQ-034 SHALL contain one state register and a next-state block; the per-state output decode is a natural combinational sub-module, mc_ctrl_decode.

Verification
REQ-035 SHALL cover: lw (100011) with mem_ready=1 -> states 0,1,2,3,4; RegWrite=1 and MemtoReg=1 in cycle 5; one instr_done pulse.
REQ-036 SHALL cover: sw (101011) with mem_ready held low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, RegWrite never 1, instr_done on the mem_ready cycle.
REQ-037 SHALL cover: beq (000100) -> states 0,1,8; PCWriteCond=1 and PCSource=01 in cycle 3; same outputs for zero=0 and zero=1.
REQ-038 SHALL cover: opcode 111111 -> illegal_op=1 in DECODE, next state FETCH, no write strobe asserted.
REQ-039 SHALL cover: rst pulsed mid-MEMRD, asynchronous and between clk edges -> all outputs 0 immediately, state=0, and FETCH resumes on the first edge after release.
REQ-040 SHALL cover: back-to-back R-type, addi, j -> 4+4+3 cycles and exactly 3 instr_done pulses.
